// File: rtl/carregador_programa_uart_if.sv
// Interface between the UART program loader and its surroundings: the
// serial input, the instruction-memory write port, the status flags and
// the state of both loader FSMs for observation.
// Optional checksum port is present only with CARREGADOR_SOMA_VERIFICACAO_EN.
//
// Handshake: the write port has no back-pressure. sinal_escrita is a
// one-cycle strobe, and endereco_escrita/dado_escrita are valid in exactly
// that cycle. The memory must accept the write in that cycle.
interface carregador_programa_uart_if #(
    parameter int END_W = 7
);
    logic             rx;
    logic [END_W-1:0] endereco_escrita;
    logic [31:0]      dado_escrita;
    logic             sinal_escrita;
    logic             carregando;
    logic             concluido;
    logic             erro_quadro;
    logic             erro_tamanho;
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
    logic             erro_soma;
`endif
    logic [1:0]       estado_rx_dbg;
    logic [2:0]       estado_carga_dbg;

    // Loader side: consumes rx and drives the memory write port and the flags.
    modport master (
        input  rx,
        output endereco_escrita, dado_escrita, sinal_escrita,
        output carregando, concluido, erro_quadro, erro_tamanho,
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
        output erro_soma,
`endif
        output estado_rx_dbg, estado_carga_dbg
    );

    // Host/memory side: drives rx and observes everything else.
    modport slave (
        output rx,
        input  endereco_escrita, dado_escrita, sinal_escrita,
        input  carregando, concluido, erro_quadro, erro_tamanho,
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
        input  erro_soma,
`endif
        input  estado_rx_dbg, estado_carga_dbg
    );
endinterface

// File: rtl/carregador_programa_uart.sv
// UART program loader. It receives 8N1 bytes, reads a 16-bit big-endian word
// count, and then packs the payload into 32-bit big-endian words. Each word is
// written to instruction memory, starting at word address 0. The core is held
// through carregando until the image is complete.
// Optional feature macro: CARREGADOR_SOMA_VERIFICACAO_EN. When it is defined,
// one trailing XOR checksum byte over the payload is expected and verified.
module carregador_programa_uart #(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200,
    parameter int END_W  = 7
) (
    input  logic clock,
    input  logic reset,
    carregador_programa_uart_if.master bus
);
    localparam int DIV_RAW = CLK_HZ / (BAUD * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [16:0] DEPTH_L = 17'(2 ** END_W);

    typedef enum logic [1:0] {OCIOSO, INICIO, DADOS, PARADA} estado_rx_t;
    typedef enum logic [2:0] {
        CAB_H, CAB_L, PALAVRA, ESCREVE, FIM
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
        , SOMA
`endif
    } estado_carga_t;

    // ---------------- serial receiver ----------------
    logic             rx_meta_q, rx_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic             tick;
    estado_rx_t       estado_rx_q;
    logic [3:0]       conta_tick_q;
    logic [2:0]       conta_bit_q;
    logic [7:0]       byte_q;
    logic             byte_ok_q;
    logic             espera_alto_q;
    logic             erro_quadro_q;

    // Two-flop synchronizer. It resets to the idle line level.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= bus.rx;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Oversampling prescaler. It is held at zero while the receiver is idle.
    always_comb begin
        tick  = 1'b0;
        div_d = div_q;
        if (estado_rx_q == OCIOSO) begin
            div_d = '0;
        end else if (div_q == DIV_W'(DIV - 1)) begin
            div_d = '0;
            tick  = 1'b1;
        end else begin
            div_d = div_q + DIV_W'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) div_q <= '0;
        else       div_q <= div_d;
    end

    // Receiver FSM. It validates the start bit at mid-bit, samples the data
    // bits every 16 ticks, and checks the stop bit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_rx_q   <= OCIOSO;
            conta_tick_q  <= '0;
            conta_bit_q   <= '0;
            byte_q        <= '0;
            byte_ok_q     <= 1'b0;
            espera_alto_q <= 1'b0;
            erro_quadro_q <= 1'b0;
        end else begin
            byte_ok_q <= 1'b0;
            case (estado_rx_q)
                OCIOSO: begin
                    if (!rx_sync_q) begin
                        estado_rx_q  <= INICIO;
                        conta_tick_q <= '0;
                    end
                end
                INICIO: begin
                    if (tick) begin
                        if (conta_tick_q == 4'd7) begin
                            if (!rx_sync_q) begin
                                estado_rx_q  <= DADOS;
                                conta_tick_q <= '0;
                                conta_bit_q  <= '0;
                            end else begin
                                estado_rx_q <= OCIOSO;
                            end
                        end else begin
                            conta_tick_q <= conta_tick_q + 4'd1;
                        end
                    end
                end
                DADOS: begin
                    if (tick) begin
                        if (conta_tick_q == 4'd15) begin
                            conta_tick_q <= '0;
                            byte_q       <= {rx_sync_q, byte_q[7:1]};
                            if (conta_bit_q == 3'd7) estado_rx_q <= PARADA;
                            else                     conta_bit_q <= conta_bit_q + 3'd1;
                        end else begin
                            conta_tick_q <= conta_tick_q + 4'd1;
                        end
                    end
                end
                PARADA: begin
                    if (espera_alto_q) begin
                        // A low stop bit leaves the line low. Wait for it to
                        // go high so that the break is not read as a new start.
                        if (rx_sync_q) begin
                            espera_alto_q <= 1'b0;
                            estado_rx_q   <= OCIOSO;
                        end
                    end else if (tick) begin
                        if (conta_tick_q == 4'd15) begin
                            if (rx_sync_q) begin
                                byte_ok_q   <= 1'b1;
                                estado_rx_q <= OCIOSO;
                            end else begin
                                erro_quadro_q <= 1'b1;
                                espera_alto_q <= 1'b1;
                            end
                        end else begin
                            conta_tick_q <= conta_tick_q + 4'd1;
                        end
                    end
                end
                default: estado_rx_q <= OCIOSO;
            endcase
        end
    end

    // ---------------- loader ----------------
    estado_carga_t    estado_carga_q;
    logic [15:0]      total_q;
    logic [15:0]      indice_q;
    logic [1:0]       conta_byte_q;
    logic [23:0]      palavra_q;
    logic [END_W-1:0] endereco_q;
    logic [31:0]      dado_q;
    logic             sinal_q;
    logic             carregando_q;
    logic             concluido_q;
    logic             erro_tamanho_q;
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
    logic [7:0]       soma_q;
    logic             erro_soma_q;
`endif

    // Loader FSM. It reads the header, packs the words, issues the writes,
    // and then parks in FIM until the next reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_carga_q <= CAB_H;
            total_q        <= '0;
            indice_q       <= '0;
            conta_byte_q   <= '0;
            palavra_q      <= '0;
            endereco_q     <= '0;
            dado_q         <= '0;
            sinal_q        <= 1'b0;
            carregando_q   <= 1'b1;
            concluido_q    <= 1'b0;
            erro_tamanho_q <= 1'b0;
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
            soma_q         <= '0;
            erro_soma_q    <= 1'b0;
`endif
        end else begin
            case (estado_carga_q)
                CAB_H: begin
                    if (byte_ok_q) begin
                        total_q[15:8]  <= byte_q;
                        estado_carga_q <= CAB_L;
                    end
                end
                CAB_L: begin
                    if (byte_ok_q) begin
                        total_q[7:0] <= byte_q;
                        if ({total_q[15:8], byte_q} == 16'd0) begin
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
                            estado_carga_q <= SOMA;
`else
                            estado_carga_q <= FIM;
                            carregando_q   <= 1'b0;
                            concluido_q    <= !erro_quadro_q && !erro_tamanho_q;
`endif
                        end else begin
                            if ({1'b0, total_q[15:8], byte_q} > DEPTH_L)
                                erro_tamanho_q <= 1'b1;
                            estado_carga_q <= PALAVRA;
                        end
                    end
                end
                PALAVRA: begin
                    if (byte_ok_q) begin
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
                        soma_q <= soma_q ^ byte_q;
`endif
                        palavra_q <= {palavra_q[15:0], byte_q};
                        if (conta_byte_q == 2'd3) begin
                            conta_byte_q   <= '0;
                            estado_carga_q <= ESCREVE;
                            // Words beyond the memory depth are consumed
                            // but never written.
                            if ({1'b0, indice_q} < DEPTH_L) begin
                                sinal_q <= 1'b1;
                                dado_q  <= {palavra_q, byte_q};
                            end
                        end else begin
                            conta_byte_q <= conta_byte_q + 2'd1;
                        end
                    end
                end
                ESCREVE: begin
                    sinal_q    <= 1'b0;
                    endereco_q <= endereco_q + END_W'(1);
                    indice_q   <= indice_q + 16'd1;
                    if (indice_q + 16'd1 == total_q) begin
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
                        estado_carga_q <= SOMA;
`else
                        estado_carga_q <= FIM;
                        carregando_q   <= 1'b0;
                        concluido_q    <= !erro_quadro_q && !erro_tamanho_q;
`endif
                    end else begin
                        estado_carga_q <= PALAVRA;
                    end
                end
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
                SOMA: begin
                    if (byte_ok_q) begin
                        estado_carga_q <= FIM;
                        carregando_q   <= 1'b0;
                        if (byte_q == soma_q) begin
                            concluido_q <= !erro_quadro_q && !erro_tamanho_q;
                        end else begin
                            erro_soma_q <= 1'b1;
                            concluido_q <= 1'b0;
                        end
                    end
                end
`endif
                FIM: begin
                    carregando_q <= 1'b0;
                end
                default: estado_carga_q <= CAB_H;
            endcase
        end
    end

    assign bus.endereco_escrita = endereco_q;
    assign bus.dado_escrita     = dado_q;
    assign bus.sinal_escrita    = sinal_q;
    assign bus.carregando       = carregando_q;
    assign bus.concluido        = concluido_q;
    assign bus.erro_quadro      = erro_quadro_q;
    assign bus.erro_tamanho     = erro_tamanho_q;
`ifdef CARREGADOR_SOMA_VERIFICACAO_EN
    assign bus.erro_soma        = erro_soma_q;
`endif
    assign bus.estado_rx_dbg    = estado_rx_q;
    assign bus.estado_carga_dbg = estado_carga_q;
endmodule
